// File: rtl/param_cpu_core.sv
// rtl/param_cpu_core.sv - parametrised multi-cycle CPU core
// One instruction per valid/ready handshake, IDLE->DEC->(EXE->WB)->DONE sequencing.
module param_cpu_core #(
  parameter int WIDTH = 8,
  parameter int NREG  = 4,
  localparam int RA   = $clog2(NREG),
  localparam int IW   = 3 + 2*RA + WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inst_valid,
  input  logic [IW-1:0]    inst,
  output logic             inst_ready,
  output logic             inst_done,
  output logic [WIDTH-1:0] out_data,
  output logic             flag_z,
  output logic             flag_c,
  input  logic [RA-1:0]    dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic [2:0] {S_IDLE, S_DEC, S_EXE, S_WB, S_DONE} state_e;
  typedef enum logic [2:0] {OP_LDI, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_OUT} op_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    ir_q, ir_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH:0]   g_q, g_d;
  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [WIDTH-1:0] out_q, out_d;
  logic             z_q, z_d;
  logic             c_q, c_d;

  op_e              op;
  logic [RA-1:0]    rd;
  logic [RA-1:0]    rs;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] b_opnd;

  assign op     = op_e'(ir_q[IW-1 -: 3]);
  assign rd     = ir_q[IW-4 -: RA];
  assign rs     = ir_q[WIDTH+RA-1 -: RA];
  assign imm    = ir_q[WIDTH-1:0];
  assign b_opnd = regs_q[rs];

  assign inst_ready = (state_q == S_IDLE) && clr;
  assign inst_done  = (state_q == S_DONE);
  assign out_data   = out_q;
  assign flag_z     = z_q;
  assign flag_c     = c_q;
  assign dbg_data   = regs_q[dbg_sel];

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    a_d     = a_q;
    g_d     = g_q;
    regs_d  = regs_q;
    out_d   = out_q;
    z_d     = z_q;
    c_d     = c_q;
    case (state_q)
      S_IDLE: begin
        if (inst_valid && inst_ready) begin
          ir_d    = inst;
          state_d = S_DEC;
        end
      end
      S_DEC: begin
        state_d = S_DONE;
        case (op)
          OP_LDI:  regs_d[rd] = imm;
          OP_MOV:  regs_d[rd] = regs_q[rs];
          OP_OUT:  out_d = regs_q[rd];
          default: begin
            // Operand A is captured here so rd==rs reads the pre-write value.
            a_d     = regs_q[rd];
            state_d = S_EXE;
          end
        endcase
      end
      S_EXE: begin
        case (op)
          OP_ADD:  g_d = {1'b0, a_q} + {1'b0, b_opnd};
          OP_SUB:  g_d = {1'b0, a_q} - {1'b0, b_opnd};
          OP_AND:  g_d = {1'b0, a_q & b_opnd};
          OP_OR:   g_d = {1'b0, a_q | b_opnd};
          default: g_d = {1'b0, a_q ^ b_opnd};
        endcase
        // Bit WIDTH of the zero-extended difference is the borrow.
        z_d     = (g_d[WIDTH-1:0] == '0);
        c_d     = g_d[WIDTH];
        state_d = S_WB;
      end
      S_WB: begin
        regs_d[rd] = g_q[WIDTH-1:0];
        state_d    = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      a_q     <= '0;
      g_q     <= '0;
      out_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      g_q     <= g_d;
      out_q   <= out_d;
      z_q     <= z_d;
      c_q     <= c_d;
      regs_q  <= regs_d;
    end
  end

endmodule
